// File: rtl/ocimem_dbg_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ocimem_dbg_pkg : jdo field map and debug FSM states for the OCI RAM sequencer
// Revision: 1.0
// ----------------------------------------------------------------------------
package ocimem_dbg_pkg;

  localparam int JDO_W           = 38;
  localparam int JDO_ADDR_LSB    = 17;
  localparam int JDO_RD_BIT      = 34;
  localparam int JDO_CLR_ERR_BIT = 33;
  localparam int JDO_WDATA_LSB   = 3;
  localparam int DATA_W          = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    RDWAIT = 2'd2
  } dbg_state_e;

endpackage
`default_nettype wire

// File: rtl/ocimem_arb2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ocimem_arb2 : two-requester arbiter, a contested cycle goes to the last loser
// Revision: 1.0
// ----------------------------------------------------------------------------
module ocimem_arb2 (
  input  logic clk,
  input  logic reset_n,
  input  logic req_dbg,
  input  logic req_cpu,
  output logic gnt_dbg,
  output logic gnt_cpu
);

  // Set when the CPU won the most recent contested cycle; resets to CPU so
  // the debug path wins the first contest.
  logic last_cpu_q;
  logic last_cpu_d;
  logic contest;

  always_comb begin
    contest    = req_dbg & req_cpu;
    gnt_dbg    = req_dbg & (~req_cpu | last_cpu_q);
    gnt_cpu    = req_cpu & (~req_dbg | ~last_cpu_q);
    last_cpu_d = last_cpu_q;
    if (contest) begin
      last_cpu_d = gnt_cpu;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_cpu_q <= 1'b1;
    end else begin
      last_cpu_q <= last_cpu_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ocimem_debug_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ocimem_debug_sequencer : sysclk OCI RAM access sequencer for the debug slave
// Revision: 1.0
// ----------------------------------------------------------------------------
module ocimem_debug_sequencer
  import ocimem_dbg_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [JDO_W-1:0]    jdo,
  input  logic                take_action_ocimem_a,
  input  logic                take_action_ocimem_b,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic                cpu_gnt,
  output logic                cpu_rvalid,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                ram_en,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic [DATA_W-1:0]   MonDReg,
  output logic                monitor_ready,
  output logic                monitor_error,
  output logic                busy
);

  dbg_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   dbg_addr_q, dbg_addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                is_wr_q, is_wr_d;
  logic [DATA_W-1:0]   mon_q, mon_d;
  logic                ready_q, ready_d;
  logic                error_q, error_d;
  logic                cpu_rvalid_q, cpu_rvalid_d;

  logic                idle;
  logic                cmd_a, cmd_b, cmd_drop;
  logic                req_dbg, req_cpu;
  logic                gnt_dbg, gnt_cpu;
  logic [ADDR_W-1:0]   jdo_addr;
  logic [DATA_W-1:0]   jdo_wdata;
  logic                jdo_rd, jdo_clr;
  logic                unused_jdo;

  assign jdo_addr   = jdo[JDO_ADDR_LSB +: ADDR_W];
  assign jdo_wdata  = jdo[JDO_WDATA_LSB +: DATA_W];
  assign jdo_rd     = jdo[JDO_RD_BIT];
  assign jdo_clr    = jdo[JDO_CLR_ERR_BIT];
  assign unused_jdo = ^{jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_WDATA_LSB-1:0]};

  // Command decode: a beats b in the same cycle; anything outside IDLE drops.
  always_comb begin
    idle     = (state_q == IDLE);
    cmd_a    = take_action_ocimem_a & idle;
    cmd_b    = take_action_ocimem_b & idle & ~take_action_ocimem_a;
    cmd_drop = (take_action_ocimem_a & ~idle) |
               (take_action_ocimem_b & (~idle | take_action_ocimem_a));
  end

  // CPU requests are masked during reset so no RAM access can occur.
  assign req_dbg = (state_q == REQ);
  assign req_cpu = cpu_req & reset_n;

  ocimem_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req_dbg (req_dbg),
    .req_cpu (req_cpu),
    .gnt_dbg (gnt_dbg),
    .gnt_cpu (gnt_cpu)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      dbg_addr_q   <= '0;
      wdata_q      <= '0;
      is_wr_q      <= 1'b0;
      mon_q        <= '0;
      ready_q      <= 1'b0;
      error_q      <= 1'b0;
      cpu_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dbg_addr_q   <= dbg_addr_d;
      wdata_q      <= wdata_d;
      is_wr_q      <= is_wr_d;
      mon_q        <= mon_d;
      ready_q      <= ready_d;
      error_q      <= error_d;
      cpu_rvalid_q <= cpu_rvalid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if ((cmd_a && jdo_rd) || cmd_b) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (gnt_dbg) begin
          state_d = is_wr_q ? IDLE : RDWAIT;
        end
      end
      RDWAIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dbg_addr_d   = dbg_addr_q;
    wdata_d      = wdata_q;
    is_wr_d      = is_wr_q;
    mon_d        = mon_q;
    ready_d      = ready_q;
    error_d      = error_q;
    cpu_rvalid_d = gnt_cpu & ~cpu_we;

    if (cmd_a) begin
      dbg_addr_d = jdo_addr;
      if (jdo_clr) begin
        error_d = 1'b0;
      end
      if (jdo_rd) begin
        is_wr_d = 1'b0;
        ready_d = 1'b0;
      end else begin
        ready_d = 1'b1;
      end
    end

    if (cmd_b) begin
      wdata_d = jdo_wdata;
      is_wr_d = 1'b1;
      ready_d = 1'b0;
    end

    // Address advances when the access is granted; it wraps naturally.
    if (gnt_dbg) begin
      dbg_addr_d = dbg_addr_q + ADDR_W'(1);
      if (is_wr_q) begin
        ready_d = 1'b1;
      end
    end

    if (state_q == RDWAIT) begin
      mon_d   = ram_rdata;
      ready_d = 1'b1;
    end

    if (cmd_drop) begin
      error_d = 1'b1;
    end
  end

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (gnt_dbg) begin
      ram_en    = 1'b1;
      ram_we    = is_wr_q;
      ram_addr  = dbg_addr_q;
      ram_wdata = is_wr_q ? wdata_q : '0;
    end else if (gnt_cpu) begin
      ram_en    = 1'b1;
      ram_we    = cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_we ? cpu_wdata : '0;
    end
  end

  assign cpu_gnt       = gnt_cpu;
  assign cpu_rvalid    = cpu_rvalid_q;
  assign cpu_rdata     = cpu_rvalid_q ? ram_rdata : '0;
  assign MonDReg       = mon_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;
  assign busy          = (state_q != IDLE);

endmodule
`default_nettype wire
